ser_addsub: RTL and testbench
=============================

SER_ADDSUB -- requirements
Module: ser_addsub

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 Parameter: CNT_W, $clog2(WIDTH)+1, bit-counter width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request an operation; sampled only in IDLE.
REQ-006 Port: mode  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 Port: A  input  WIDTH  first operand; sampled with start.
REQ-008 Port: B  input  WIDTH  second operand; sampled with start.
REQ-009 Port: busy  output  1  high while an operation is in progress (RUN).
REQ-010 Port: done  output  1  one-cycle pulse when Sum/Cout/Ovf become valid.
REQ-011 Port: Sum  output  WIDTH  result, held stable from done until the next accepted start.
REQ-012 Port: Cout  output  1  carry out of the MSB (borrow-not for subtract).
REQ-013 Port: Ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE: start=1 SHALL latch A, B, mode into internal shift registers, clear the bit counter, preload the carry flop with mode, and go to RUN; start=0 SHALL leave the state in IDLE.
REQ-016 Subtract SHALL be computed as A + ~B + 1: the B bit SHALL be inverted per cycle and the carry flop SHALL be preloaded with 1.
REQ-017 RUN: each cycle SHALL add one bit pair LSB-first with the stored carry, shift the sum bit into the MSB of the result register, shift the operands right, update the carry flop, and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles, after which the state SHALL go to DONE.
REQ-019 On the last RUN cycle, Cout SHALL capture the MSB carry out, and Ovf SHALL capture carry-into-MSB XOR carry-out-of-MSB.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-021 Latency from the accepting start edge to done high SHALL be WIDTH+1 cycles.
REQ-022 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-023 start during RUN or DONE SHALL be ignored, with no queuing.
REQ-024 start held high continuously SHALL begin a new operation on each IDLE visit, giving back-to-back operations every WIDTH+2 cycles.
REQ-025 Sum, Cout and Ovf SHALL NOT change in IDLE; they SHALL hold the last result.
REQ-026 Sum SHALL change only during RUN; partial values are visible during RUN and are undefined for the user.
REQ-027 The counter SHALL NOT wrap; no RUN cycle SHALL occur beyond WIDTH.

Reset
REQ-028 reset low SHALL immediately force IDLE, busy=0, done=0, Sum=0, Cout=0, Ovf=0, the carry flop to 0, and the counter to 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and no partial result retained.
REQ-030 The first start SHALL be accepted on the first rising clk after reset deasserts.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the mode constants (MODE_ADD=0, MODE_SUB=1).
REQ-032 The design SHALL contain one sub-module, fa_bit: a combinational 1-bit full adder (a, b, cin -> s, cout), instantiated once.
REQ-033 The carry flop and the shift registers SHALL live in ser_addsub.

Verification (WIDTH=8)
REQ-034 Add: A=8'h35, B=8'h4A, mode=0 -> done 9 cycles after start, Sum=8'h7F, Cout=0, Ovf=0.
REQ-035 Add with carry and overflow: A=8'h80, B=8'h80, mode=0 -> Sum=8'h00, Cout=1, Ovf=1; A=8'h7F, B=8'h01 -> Sum=8'h80, Cout=0, Ovf=1.
REQ-036 Subtract: A=8'h10, B=8'h20, mode=1 -> Sum=8'hF0, Cout=0, Ovf=0; A=8'h80, B=8'h01 -> Sum=8'h7F, Cout=1, Ovf=1.
REQ-037 Busy rejection: a second start with different operands 3 cycles into RUN -> first result unchanged, exactly one done pulse.
REQ-038 Reset mid-RUN: reset low at RUN cycle 4 -> busy=0, Sum=0, no done; a new start after release -> correct result.
REQ-039 Back-to-back: start held high over 3 operand sets -> done pulses spaced 10 cycles apart, each result correct against a reference model over random A, B, mode.

Source files
------------

// File: rtl/ser_addsub_pkg.sv
// rtl/ser_addsub_pkg.sv - shared state encoding and mode constants for ser_addsub
package ser_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/ser_addsub_if.sv
// rtl/ser_addsub_if.sv - request/result bundle between a requester and ser_addsub
interface ser_addsub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output start, mode, A, B,
    input  busy, done, Sum, Cout, Ovf
  );

  modport slave (
    input  start, mode, A, B,
    output busy, done, Sum, Cout, Ovf
  );

endinterface

// File: rtl/ser_addsub_fa_bit.sv
// rtl/ser_addsub_fa_bit.sv - combinational 1-bit full adder
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ser_addsub.sv
// rtl/ser_addsub.sv - bit-serial add/subtract, one bit pair per clock, LSB first
module ser_addsub
  import ser_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  ser_addsub_if.slave  bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               mode_q, mode_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               b_bit;
  logic               fa_s;
  logic               fa_co;

  // Subtraction inverts B on the fly; the +1 comes from the preloaded carry.
  assign b_bit = (mode_q == MODE_SUB) ? ~b_q[0] : b_q[0];

  fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_bit),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          mode_d  = bus.mode;
          carry_d = (bus.mode == MODE_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        // Last bit pair is the MSB: carry_q is the carry into it.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_ser_addsub.sv
// tb/tb_ser_addsub.sv - directed self-checking bench for ser_addsub (WIDTH=8)
module tb_ser_addsub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ser_addsub_if #(.WIDTH(W)) bus ();

  ser_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {cout, ovf, sum}.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [7:0] bb;
    logic [8:0] t;
    bb = m ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {8'd0, m};
    return {t[8], (a[7] == bb[7]) && (t[7] != a[7]), t[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic [7:0] exp_sum, input logic exp_c, input logic exp_v);
    int lat;
    int d0;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.mode = m; bus.start = 1'b1;
    d0 = done_cnt;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 9);
    check({tag, "_sum"}, bus.Sum, exp_sum);
    check({tag, "_cout"}, bus.Cout, exp_c);
    check({tag, "_ovf"}, bus.Ovf, exp_v);
    tick();
    check({tag, "_done_1cyc"}, bus.done, 1'b0);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    repeat (3) tick();
    check({tag, "_hold"}, {bus.Cout, bus.Ovf, bus.Sum}, {exp_c, exp_v, exp_sum});
  endtask

  initial begin
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vm [3];
    int         t_done [3];
    int         k;
    int         idx;
    int         d0;
    logic       prev_busy;

    bus.start = 1'b0; bus.mode = 1'b0; bus.A = '0; bus.B = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_state", {bus.Cout, bus.Ovf, bus.Sum}, 10'd0);

    // Start presented while reset releases: accepted on the very next edge.
    @(negedge clk);
    reset = 1'b1;
    bus.A = 8'h35; bus.B = 8'h4A; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("first_accept", bus.busy, 1'b1);
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) tick();
    check("first_sum", bus.Sum, 8'h7F);
    repeat (2) tick();

    run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Reset at RUN cycle 4 with Cout/Ovf still 1 from the previous result.
    @(negedge clk);
    bus.A = 8'h12; bus.B = 8'h34; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_state", {bus.Cout, bus.Ovf, bus.Sum}, 10'd0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (12) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Second start 3 cycles into RUN must be ignored.
    d0 = done_cnt;
    @(negedge clk);
    bus.A = 8'h35; bus.B = 8'h4A; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.A = 8'hFF; bus.B = 8'hFF; bus.mode = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    check("busyrej_done_cnt", done_cnt - d0, 1);
    check("busyrej_sum", {bus.Cout, bus.Ovf, bus.Sum}, {2'b00, 8'h7F});

    // Back-to-back with start held high.
    for (int i = 0; i < 3; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
      vm[i] = 1'($urandom);
    end
    @(negedge clk);
    bus.A = va[0]; bus.B = vb[0]; bus.mode = vm[0]; bus.start = 1'b1;
    idx = 0; k = 0; prev_busy = 1'b0;
    for (int cyc = 1; cyc <= 60 && k < 3; cyc++) begin
      tick();
      if (bus.busy && !prev_busy) begin
        idx++;
        if (idx < 3) begin
          bus.A = va[idx]; bus.B = vb[idx]; bus.mode = vm[idx];
        end else begin
          bus.start = 1'b0;
        end
      end
      prev_busy = bus.busy;
      if (bus.done === 1'b1) begin
        check($sformatf("b2b_res%0d", k), {bus.Cout, bus.Ovf, bus.Sum}, ref_op(va[k], vb[k], vm[k]));
        t_done[k] = cyc;
        k++;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", k, 3);
    if (k == 3) begin
      check("b2b_gap1", t_done[1] - t_done[0], 10);
      check("b2b_gap2", t_done[2] - t_done[1], 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
